clken_gen: RTL and testbench

//  Parametrised clock-enable generator and lock-qualified reset sequencer, placed behind the MMCM/BUFGCE clock generator.

---
 rtl/clken_gen_pkg.sv | 11 +
 rtl/clken_gen_if.sv | 24 ++
 rtl/clken_gen_div_ch.sv | 45 ++++
 rtl/clken_gen.sv | 113 +++++++++++
 tb/tb_clken_gen.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clken_gen_pkg.sv
// Shared types for the clock-enable generator: sequencer state encoding.
package clken_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } state_t;

endpackage

// File: rtl/clken_gen_if.sv
// Divisor configuration bus of clken_gen, plus the phase-realign pulse.
// cfg_wr is a one-cycle strobe with no backpressure; every write is answered one
// cycle later by exactly one pulse: cfg_ack (applied) or cfg_err (channel out of range).
interface clken_gen_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             sync_all;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_div, sync_all,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_div, sync_all,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/clken_gen_div_ch.sv
// One enable channel: down-counter plus shadow divisor. The divisor in force for
// the running period lives only in cnt, so a new value never truncates a period.
module clken_gen_div_ch #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DIV_INIT_CH = CNT_W'(10)
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             run_en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clken
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] reload;

    // A write in the reload cycle itself is already the divisor for the next period.
    always_comb begin
        div_next = wr ? wr_div : shadow;
        reload   = (div_next <= CNT_W'(1)) ? '0 : div_next - CNT_W'(1);
    end

    assign clken = run_en && (cnt == '0);

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            cnt    <= '0;
            shadow <= DIV_INIT_CH;
        end else begin
            if (wr) begin
                shadow <= wr_div;
            end
            if (!run_en || sync) begin
                cnt <= '0;
            end else if (cnt == '0) begin
                cnt <= reload;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/clken_gen.sv
// Clock-enable generator with lock-qualified reset sequencing: NUM_CH phase-aligned
// enable strobes, released only after MMCM lock has been stable for LOCK_STABLE cycles.
module clken_gen
    import clken_gen_pkg::*;
#(
    parameter int                        NUM_CH      = 4,
    parameter int                        CH_W        = 2,
    parameter int                        CNT_W       = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT    = {4{16'd10}},
    parameter int                        LOCK_STABLE = 1024,
    parameter int                        LOCK_W      = 11
) (
    input  logic              clk,
    input  logic              reset_async,
    input  logic              clk_locked,
    clken_gen_if.slave        cfg,
    output logic [NUM_CH-1:0] clken,
    output logic              run,
    output logic              reset_sync,
    output state_t            state_dbg
);
    logic              lock_meta;
    logic              lock_s;
    state_t            state;
    state_t            state_n;
    logic [LOCK_W-1:0] lock_cnt;
    logic [NUM_CH-1:0] ch_sel;
    logic              cfg_hit;
    logic              cfg_ack_q;
    logic              cfg_err_q;
    logic              run_en;

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= clk_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_WAIT_LOCK: if (lock_s) state_n = ST_STABLE;
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (lock_cnt == LOCK_W'(LOCK_STABLE - 1)) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN:  if (!lock_s) state_n = ST_LOST;
            ST_LOST: state_n = ST_WAIT_LOCK;
            default: state_n = ST_WAIT_LOCK;
        endcase
    end

    // run/reset_sync come from the next state so they toggle on the state-entry edge.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state      <= ST_WAIT_LOCK;
            lock_cnt   <= '0;
            run        <= 1'b0;
            reset_sync <= 1'b1;
        end else begin
            state      <= state_n;
            run        <= (state_n == ST_RUN);
            reset_sync <= (state_n != ST_RUN);
            if (state == ST_WAIT_LOCK) begin
                lock_cnt <= '0;
            end else if (state == ST_STABLE && lock_s) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end
        end
    end

    assign run_en    = (state == ST_RUN);
    assign state_dbg = state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_sel[i] = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));

        clken_gen_div_ch #(
            .CNT_W       (CNT_W),
            .DIV_INIT_CH (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk         (clk),
            .reset_async (reset_async),
            .run_en      (run_en),
            .sync        (cfg.sync_all),
            .wr          (ch_sel[i]),
            .wr_div      (cfg.cfg_div),
            .clken       (clken[i])
        );
    end

    assign cfg_hit = |ch_sel;

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg.cfg_wr && cfg_hit;
            cfg_err_q <= cfg.cfg_wr && !cfg_hit;
        end
    end

    assign cfg.cfg_ack = cfg_ack_q;
    assign cfg.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: lock sequencing, divider periods, config bus,
// realignment and async reset, against an absolute-time strobe schedule model.
module tb_clken_gen;
    import clken_gen_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int CH_W        = 3;
    localparam int CNT_W       = 16;
    localparam int LOCK_STABLE = 16;
    localparam int LOCK_W      = 5;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd0, 16'd10, 16'd4, 16'd1};
    localparam logic [NUM_CH-1:0] ALL_CH = '1;
    localparam int RUN_LAT = 2 + 1 + LOCK_STABLE;

    logic              clk = 1'b0;
    logic              reset_async;
    logic              clk_locked;
    logic [NUM_CH-1:0] clken;
    logic              run;
    logic              reset_sync;
    state_t            state_dbg;

    clken_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_bus ();

    clken_gen #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .CNT_W       (CNT_W),
        .DIV_INIT    (DIV_INIT),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_W      (LOCK_W)
    ) dut (
        .clk         (clk),
        .reset_async (reset_async),
        .clk_locked  (clk_locked),
        .cfg         (cfg_bus.slave),
        .clken       (clken),
        .run         (run),
        .reset_sync  (reset_sync),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;

    // Model: each channel strobes at an absolute cycle next_t; on a strobe the next
    // one is scheduled max(div,1) cycles later using the most recently written divisor.
    int mcyc;
    int next_t[NUM_CH];
    int pend_div[NUM_CH];
    int strobe_cnt[NUM_CH];
    logic [1:0] exp_q[$];

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] div;
        logic             sync;
        logic             exp_ack;
        logic             exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int init_div(input int i);
        logic [NUM_CH*CNT_W-1:0] d;
        d = DIV_INIT;
        return int'(d[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_start();
        mcyc = 0;
        exp_q.delete();
        exp_q.push_back(2'b00);
        for (int i = 0; i < NUM_CH; i++) begin
            next_t[i]     = 0;
            strobe_cnt[i] = 0;
        end
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge; checks this cycle, drives its inputs, advances one cycle.
    task automatic cycle(input logic wr, input logic [CH_W-1:0] ch,
                         input logic [CNT_W-1:0] div, input logic sync);
        logic [NUM_CH-1:0] exp_ck;
        logic [1:0]        exp_ae;
        int                period;
        for (int i = 0; i < NUM_CH; i++) exp_ck[i] = (next_t[i] == mcyc);
        chk("clken", clken, exp_ck);
        if (exp_q.size() > 0) begin
            exp_ae = exp_q.pop_front();
            chk("cfg_ack", cfg_bus.cfg_ack, exp_ae[1]);
            chk("cfg_err", cfg_bus.cfg_err, exp_ae[0]);
        end
        for (int i = 0; i < NUM_CH; i++) strobe_cnt[i] += int'(clken[i]);
        cfg_bus.cfg_wr   = wr;
        cfg_bus.cfg_ch   = ch;
        cfg_bus.cfg_div  = div;
        cfg_bus.sync_all = sync;
        if (wr && int'(ch) < NUM_CH) pend_div[ch] = int'(div);
        for (int i = 0; i < NUM_CH; i++) begin
            period = (pend_div[i] > 1) ? pend_div[i] : 1;
            if (sync) next_t[i] = mcyc + 1;
            else if (exp_ck[i]) next_t[i] = mcyc + period;
        end
        exp_q.push_back({wr && (int'(ch) < NUM_CH), wr && (int'(ch) >= NUM_CH)});
        @(posedge clk);
        #1;
        cfg_bus.cfg_wr   = 1'b0;
        cfg_bus.sync_all = 1'b0;
        mcyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    // Raise lock and count edges until run; checks exact latency and the aligned first strobe.
    task automatic wait_run(input string name);
        int n;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (run) break;
        end
        if (!run) n = 61;
        chk({name, "_latency"}, n, RUN_LAT);
        chk({name, "_first_clken"}, clken, ALL_CH);
        chk({name, "_reset_sync"}, reset_sync, 0);
    endtask

    initial begin
        #2_000_000;
        mismatched++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int hits[$];
        bit saw_wl;
        int n;

        vecs[0] = '{ch: 3'd0, div: 16'd2, sync: 1'b0, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[1] = '{ch: 3'd3, div: 16'd5, sync: 1'b0, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[2] = '{ch: 3'd4, div: 16'd1, sync: 1'b0, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[3] = '{ch: 3'd7, div: 16'd9, sync: 1'b0, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[4] = '{ch: 3'd2, div: 16'd0, sync: 1'b1, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[5] = '{ch: 3'd1, div: 16'd1, sync: 1'b0, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[6] = '{ch: 3'd3, div: 16'd0, sync: 1'b1, exp_ack: 1'b1, exp_err: 1'b0};
        for (int i = 0; i < NUM_CH; i++) pend_div[i] = init_div(i);

        reset_async      = 1'b1;
        clk_locked       = 1'b0;
        cfg_bus.cfg_wr   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_div  = '0;
        cfg_bus.sync_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clken", clken, 0);
        chk("rst_run", run, 0);
        chk("rst_reset_sync", reset_sync, 1);
        chk("rst_ack", cfg_bus.cfg_ack, 0);
        chk("rst_err", cfg_bus.cfg_err, 0);
        chk("rst_state", state_dbg, ST_WAIT_LOCK);
        reset_async = 1'b0;
        @(posedge clk);
        #1;

        // lock-to-run latency, all channels aligned
        clk_locked = 1'b1;
        wait_run("lock1");

        // DIV_INIT periods over 100 cycles
        model_start();
        idle(100);
        chk("cnt100_ch0", strobe_cnt[0], 100);
        chk("cnt100_ch1", strobe_cnt[1], 25);
        chk("cnt100_ch2", strobe_cnt[2], 10);
        chk("cnt100_ch3", strobe_cnt[3], 100);

        // mid-period write to ch1: old period of 4 completes, then period 3
        idle(1);
        cycle(1'b1, 3'd1, 16'd3, 1'b0);
        chk("wr_ch1_ack", cfg_bus.cfg_ack, 1);
        chk("wr_ch1_err", cfg_bus.cfg_err, 0);
        for (int k = 0; k < 10; k++) begin
            if (clken[1]) hits.push_back(mcyc);
            idle(1);
        end
        chk("ch1_hits", hits.size(), 3);
        if (hits.size() == 3) begin
            chk("ch1_hit0", hits[0], 104);
            chk("ch1_hit1", hits[1], 107);
            chk("ch1_hit2", hits[2], 110);
        end

        // out-of-range channel
        cycle(1'b1, 3'd5, 16'd2, 1'b0);
        chk("bad_ch_err", cfg_bus.cfg_err, 1);
        chk("bad_ch_ack", cfg_bus.cfg_ack, 0);
        idle(20);

        // table vectors
        foreach (vecs[v]) begin
            cycle(1'b1, vecs[v].ch, vecs[v].div, vecs[v].sync);
            chk("vec_ack", cfg_bus.cfg_ack, vecs[v].exp_ack);
            chk("vec_err", cfg_bus.cfg_err, vecs[v].exp_err);
            if (vecs[v].sync) chk("vec_sync_clken", clken, ALL_CH);
            idle(11);
        end

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            cycle($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                  16'($urandom_range(0, 6)), $urandom_range(0, 19) == 0);
        end

        // lock loss in RUN: enables off and reset asserted within 3 cycles
        clk_locked = 1'b0;
        n = 4;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (clken == '0 && reset_sync) begin
                n = k;
                break;
            end
        end
        chk("loss_within_3", n <= 3, 1);
        chk("loss_state", state_dbg, ST_LOST);
        chk("loss_run", run, 0);
        @(posedge clk);
        #1;
        chk("loss_to_wait", state_dbg, ST_WAIT_LOCK);

        // relock, one-cycle lock glitch in STABLE restarts the full count
        clk_locked = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (state_dbg == ST_STABLE) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("relock_stable", state_dbg, ST_STABLE);
        repeat (5) @(posedge clk);
        #1;
        clk_locked = 1'b0;
        @(posedge clk);
        #1;
        clk_locked = 1'b1;
        saw_wl = 1'b0;
        n = 61;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (state_dbg == ST_WAIT_LOCK) saw_wl = 1'b1;
            if (run) begin
                n = k;
                break;
            end
        end
        chk("glitch_wait_lock", saw_wl, 1);
        chk("glitch_latency", n, RUN_LAT);
        chk("relock_first_clken", clken, ALL_CH);

        // realigned operation, explicit sync_all mid-run
        model_start();
        idle(15);
        cycle(1'b0, '0, '0, 1'b1);
        chk("sync_all_clken", clken, ALL_CH);
        idle(15);

        // async reset mid-run restores divisors to DIV_INIT
        #2;
        reset_async = 1'b1;
        #1;
        chk("arst_clken", clken, 0);
        chk("arst_run", run, 0);
        chk("arst_reset_sync", reset_sync, 1);
        chk("arst_state", state_dbg, ST_WAIT_LOCK);
        @(posedge clk);
        #1;
        reset_async = 1'b0;
        for (int i = 0; i < NUM_CH; i++) pend_div[i] = init_div(i);
        wait_run("lock2");
        model_start();
        idle(40);
        chk("arst_cnt_ch1", strobe_cnt[1], 10);
        chk("arst_cnt_ch2", strobe_cnt[2], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
